// File: rtl/price_window_if.sv
// price_window_if
//   Bundles the price stream, the indexed read port and the window status
//   of price_window_buffer into one interface.
//   master : price source / indicator engines (drive price_in, new_price, clear, rd_en, rd_idx)
//   slave  : price_window_buffer (drives rd_data, rd_valid and all status outputs)
//   Optional macro PRICE_WIN_DELTA_EN adds delta_gain / delta_loss.
interface price_window_if #(
    parameter int PRICE_W = 16,
    parameter int CNT_W   = 5,
    parameter int SUM_W   = 32
);
    logic [PRICE_W-1:0] price_in;
    logic               new_price;
    logic               clear;
    logic               rd_en;
    logic [CNT_W-1:0]   rd_idx;
    logic [PRICE_W-1:0] rd_data;
    logic               rd_valid;
    logic [CNT_W-1:0]   mem_cnt;
    logic               mem_full;
    logic [PRICE_W-1:0] oldest_price;
    logic [PRICE_W-1:0] newest_price;
    logic [SUM_W-1:0]   window_sum;
    logic               win_update;
`ifdef PRICE_WIN_DELTA_EN
    logic [PRICE_W-1:0] delta_gain;
    logic [PRICE_W-1:0] delta_loss;
`endif

    modport master (
        output price_in, new_price, clear, rd_en, rd_idx,
        input  rd_data, rd_valid, mem_cnt, mem_full, oldest_price, newest_price,
               window_sum, win_update
`ifdef PRICE_WIN_DELTA_EN
        , input delta_gain, delta_loss
`endif
    );

    modport slave (
        input  price_in, new_price, clear, rd_en, rd_idx,
        output rd_data, rd_valid, mem_cnt, mem_full, oldest_price, newest_price,
               window_sum, win_update
`ifdef PRICE_WIN_DELTA_EN
        , output delta_gain, delta_loss
`endif
    );
endinterface

// File: rtl/price_window_buffer.sv
// price_window_buffer
//   Keeps the last DEPTH prices in a circular window with a running sum,
//   fill status, oldest/newest price and a registered indexed read port.
//   Ports: clk, rst (async, active-high), bus (price_window_if.slave).
//   Optional macro PRICE_WIN_DELTA_EN adds delta_gain / delta_loss outputs,
//   updated together with win_update.
module price_window_buffer #(
    parameter int DEPTH   = 14,
    parameter int PRICE_W = 16,
    parameter int CNT_W   = 5,
    parameter int SUM_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    price_window_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W+1)'(DEPTH);

    logic [PRICE_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   mem_cnt;
    logic [SUM_W-1:0]   window_sum;

    logic               full;
    logic               empty;
    logic               accept;
    logic [CNT_W-1:0]   oldest_addr;
    logic [CNT_W-1:0]   newest_addr;
    logic [PRICE_W-1:0] oldest_word;
    logic [PRICE_W-1:0] newest_word;
    logic [PRICE_W-1:0] evict_word;
    logic [CNT_W:0]     rd_sum;
    logic [CNT_W:0]     rd_phys;
    logic [SUM_W-1:0]   sum_next;

    assign full   = (mem_cnt == FULL_CNT);
    assign empty  = (mem_cnt == '0);
    assign accept = bus.new_price && !bus.clear;

    // Once full, the slot about to be overwritten is the oldest entry.
    assign oldest_addr = full ? wr_ptr : '0;
    assign newest_addr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    assign oldest_word = mem[oldest_addr[AW-1:0]];
    assign newest_word = mem[newest_addr[AW-1:0]];
    assign evict_word  = full ? mem[wr_ptr[AW-1:0]] : '0;

    // Both operands are < DEPTH, so one conditional subtract is the modulo.
    assign rd_sum  = {1'b0, oldest_addr} + {1'b0, bus.rd_idx};
    assign rd_phys = (rd_sum >= DEPTH_X) ? rd_sum - DEPTH_X : rd_sum;

    assign sum_next = window_sum - SUM_W'(evict_word) + SUM_W'(bus.price_in);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= bus.price_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            mem_cnt    <= '0;
            window_sum <= '0;
        end else if (bus.clear) begin
            wr_ptr     <= '0;
            mem_cnt    <= '0;
            window_sum <= '0;
        end else if (bus.new_price) begin
            wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            mem_cnt    <= full ? mem_cnt : mem_cnt + 1'b1;
            window_sum <= sum_next;
        end
    end

    // Reads use pre-edge state, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_data    <= '0;
            bus.rd_valid   <= 1'b0;
            bus.win_update <= 1'b0;
        end else begin
            bus.rd_valid   <= bus.rd_en;
            bus.win_update <= accept;
            if (bus.rd_en) begin
                bus.rd_data <= (bus.rd_idx < mem_cnt) ? mem[rd_phys[AW-1:0]] : '0;
            end
        end
    end

    assign bus.mem_cnt      = mem_cnt;
    assign bus.mem_full     = full;
    assign bus.window_sum   = window_sum;
    assign bus.oldest_price = empty ? '0 : oldest_word;
    assign bus.newest_price = empty ? '0 : newest_word;

`ifdef PRICE_WIN_DELTA_EN
    // The previous price is the current newest; an empty window has none.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.delta_gain <= '0;
            bus.delta_loss <= '0;
        end else if (bus.clear) begin
            bus.delta_gain <= '0;
            bus.delta_loss <= '0;
        end else if (bus.new_price) begin
            if (empty) begin
                bus.delta_gain <= '0;
                bus.delta_loss <= '0;
            end else if (bus.price_in > newest_word) begin
                bus.delta_gain <= bus.price_in - newest_word;
                bus.delta_loss <= '0;
            end else begin
                bus.delta_gain <= '0;
                bus.delta_loss <= newest_word - bus.price_in;
            end
        end
    end
`endif
endmodule
